// File: rtl/sorting_pp.sv
// Ping-pong Avalon-ST packet sorter: two RAM banks, one odd-even transposition sort engine.
// One bank receives a packet while the other is sorted or streamed out, in arrival order.
module sorting_pp #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 256
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              sort_desc_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              overflow_o
);

  localparam int unsigned ADDR_SZ = $clog2(MAX_PKT_LEN);
  localparam int unsigned CW      = ADDR_SZ + 1;
  localparam logic [CW-1:0] MAX_LEN = CW'(MAX_PKT_LEN);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_SORT = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_CHK  = 2'd1;
  localparam logic [1:0] E_WR   = 2'd2;

  // Per-bank state
  logic [1:0]        bank_st       [2];
  logic [1:0]        bank_st_nxt   [2];
  logic [CW-1:0]     bank_len      [2];
  logic [CW-1:0]     bank_len_nxt  [2];
  logic              bank_desc     [2];
  logic              bank_desc_nxt [2];

  // Sink side
  logic              wr_bank, wr_bank_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              sink_beat;
  logic              sink_we;
  logic [ADDR_SZ-1:0] sink_wa;
  logic              snk_ready_nxt;
  logic              overflow_nxt;

  // Sort engine
  logic              sort_bank, sort_bank_nxt;
  logic [1:0]        eng_st, eng_st_nxt;
  logic [CW-1:0]     pass, pass_nxt;
  logic [CW-1:0]     idx, idx_nxt;
  logic              eng_re, eng_we;
  logic [DWIDTH-1:0] eng_qa, eng_qb;
  logic              eng_swap;

  // Send side: RAM read register acts as the prefetch stage
  logic              send_bank, send_bank_nxt;
  logic [CW-1:0]     fcnt, fcnt_nxt;
  logic              fv, fv_nxt, fsop, fsop_nxt, feop, feop_nxt;
  logic              send_re, send_adv;
  logic [DWIDTH-1:0] fdata;
  logic              src_valid_nxt, src_sop_nxt, src_eop_nxt;
  logic [DWIDTH-1:0] src_data_nxt;

  // RAM banks and their muxed ports
  logic [DWIDTH-1:0]  mem  [2][MAX_PKT_LEN];
  logic [DWIDTH-1:0]  q_a  [2];
  logic [DWIDTH-1:0]  q_b  [2];
  logic               we_a [2];
  logic               we_b [2];
  logic               re_a [2];
  logic               re_b [2];
  logic [ADDR_SZ-1:0] wa_a [2];
  logic [ADDR_SZ-1:0] wa_b [2];
  logic [ADDR_SZ-1:0] ra_a [2];
  logic [ADDR_SZ-1:0] ra_b [2];
  logic [DWIDTH-1:0]  wd_a [2];
  logic [DWIDTH-1:0]  wd_b [2];

  assign eng_qa   = q_a[sort_bank];
  assign eng_qb   = q_b[sort_bank];
  assign eng_swap = bank_desc[sort_bank] ? (eng_qa < eng_qb) : (eng_qa > eng_qb);
  assign fdata    = q_a[send_bank];

  // Next-state logic for bank FSMs, sink capture, sort engine and send pipeline
  always_comb begin
    bank_st_nxt   = bank_st;
    bank_len_nxt  = bank_len;
    bank_desc_nxt = bank_desc;
    wr_bank_nxt   = wr_bank;
    cnt_nxt       = cnt;
    overflow_nxt  = 1'b0;
    sort_bank_nxt = sort_bank;
    eng_st_nxt    = eng_st;
    pass_nxt      = pass;
    idx_nxt       = idx;
    send_bank_nxt = send_bank;
    fcnt_nxt      = fcnt;
    fv_nxt        = fv;
    fsop_nxt      = fsop;
    feop_nxt      = feop;
    src_valid_nxt = src_valid_o;
    src_data_nxt  = src_data_o;
    src_sop_nxt   = src_startofpacket_o;
    src_eop_nxt   = src_endofpacket_o;
    sink_we       = 1'b0;
    sink_wa       = '0;
    eng_re        = 1'b0;
    eng_we        = 1'b0;
    sink_beat     = snk_valid_i & snk_ready_o;

    // Sink: SOP (re)starts the write bank, EOP closes it and flips the write bank
    if (sink_beat) begin
      if (snk_startofpacket_i) begin
        sink_we                = 1'b1;
        sink_wa                = '0;
        bank_desc_nxt[wr_bank] = sort_desc_i;
        if (snk_endofpacket_i) begin
          bank_len_nxt[wr_bank] = CW'(1);
          bank_st_nxt[wr_bank]  = ST_SORT;
          wr_bank_nxt           = ~wr_bank;
          cnt_nxt               = '0;
        end else begin
          bank_st_nxt[wr_bank] = ST_FILL;
          cnt_nxt              = CW'(1);
        end
      end else if (bank_st[wr_bank] == ST_FILL) begin
        if (cnt != MAX_LEN) begin
          sink_we = 1'b1;
          sink_wa = cnt[ADDR_SZ-1:0];
        end
        if (snk_endofpacket_i) begin
          bank_len_nxt[wr_bank] = (cnt == MAX_LEN) ? MAX_LEN : cnt + CW'(1);
          overflow_nxt          = (cnt == MAX_LEN);
          bank_st_nxt[wr_bank]  = ST_SORT;
          wr_bank_nxt           = ~wr_bank;
          cnt_nxt               = '0;
        end else if (cnt != MAX_LEN) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    // Sort engine: len passes, each a sweep of read-pair / conditional swap-write
    case (eng_st)
      E_IDLE: begin
        if (bank_st[sort_bank] == ST_SORT) begin
          if (bank_len[sort_bank] == CW'(1)) begin
            bank_st_nxt[sort_bank] = ST_SEND;
            sort_bank_nxt          = ~sort_bank;
          end else begin
            pass_nxt   = '0;
            idx_nxt    = '0;
            eng_st_nxt = E_CHK;
          end
        end
      end
      E_CHK: begin
        if (pass == bank_len[sort_bank]) begin
          bank_st_nxt[sort_bank] = ST_SEND;
          sort_bank_nxt          = ~sort_bank;
          eng_st_nxt             = E_IDLE;
        end else if ((idx + CW'(1)) < bank_len[sort_bank]) begin
          eng_re     = 1'b1;
          eng_st_nxt = E_WR;
        end else begin
          pass_nxt = pass + CW'(1);
          idx_nxt  = pass[0] ? '0 : CW'(1);
        end
      end
      E_WR: begin
        eng_we     = eng_swap;
        idx_nxt    = idx + CW'(2);
        eng_st_nxt = E_CHK;
      end
      default: eng_st_nxt = E_IDLE;
    endcase

    // Send: fetch one word ahead; the output register only advances when free or accepted
    send_adv = ~src_valid_o | src_ready_i;
    send_re  = (bank_st[send_bank] == ST_SEND) && (fcnt < bank_len[send_bank]) &&
               (send_adv || !fv);
    if (send_re) begin
      fcnt_nxt = fcnt + CW'(1);
      fv_nxt   = 1'b1;
      fsop_nxt = (fcnt == '0);
      feop_nxt = (fcnt == bank_len[send_bank] - CW'(1));
    end else if (send_adv) begin
      fv_nxt = 1'b0;
    end
    if (send_adv) begin
      src_valid_nxt = fv;
      src_data_nxt  = fv ? fdata : '0;
      src_sop_nxt   = fv & fsop;
      src_eop_nxt   = fv & feop;
    end
    if (src_valid_o && src_ready_i && src_endofpacket_o) begin
      bank_st_nxt[send_bank] = ST_FREE;
      send_bank_nxt          = ~send_bank;
      fcnt_nxt               = '0;
    end

    snk_ready_nxt = (bank_st_nxt[wr_bank_nxt] == ST_FREE) ||
                    (bank_st_nxt[wr_bank_nxt] == ST_FILL);
  end

  // RAM port mux: each bank is driven by whichever agent owns it in its current state
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we_a[b] = 1'b0;
      we_b[b] = 1'b0;
      re_a[b] = 1'b0;
      re_b[b] = 1'b0;
      wa_a[b] = '0;
      wa_b[b] = '0;
      ra_a[b] = '0;
      ra_b[b] = '0;
      wd_a[b] = '0;
      wd_b[b] = '0;
      if ((eng_st != E_IDLE) && (sort_bank == 1'(b))) begin
        re_a[b] = eng_re;
        re_b[b] = eng_re;
        ra_a[b] = idx[ADDR_SZ-1:0];
        ra_b[b] = ADDR_SZ'(idx + CW'(1));
        we_a[b] = eng_we;
        we_b[b] = eng_we;
        wa_a[b] = idx[ADDR_SZ-1:0];
        wa_b[b] = ADDR_SZ'(idx + CW'(1));
        wd_a[b] = q_b[b];
        wd_b[b] = q_a[b];
      end else if ((bank_st[b] == ST_SEND) && (send_bank == 1'(b))) begin
        re_a[b] = send_re;
        ra_a[b] = fcnt[ADDR_SZ-1:0];
      end else if (wr_bank == 1'(b)) begin
        we_a[b] = sink_we;
        wa_a[b] = sink_wa;
        wd_a[b] = snk_data_i;
      end
    end
  end

  // Two-port RAM banks with registered reads
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 2; b++) begin
      if (we_a[b]) mem[b][wa_a[b]] <= wd_a[b];
      if (we_b[b]) mem[b][wa_b[b]] <= wd_b[b];
      if (re_a[b]) q_a[b] <= mem[b][ra_a[b]];
      if (re_b[b]) q_b[b] <= mem[b][ra_b[b]];
    end
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int b = 0; b < 2; b++) begin
        bank_st[b]   <= ST_FREE;
        bank_len[b]  <= '0;
        bank_desc[b] <= 1'b0;
      end
      wr_bank             <= 1'b0;
      cnt                 <= '0;
      sort_bank           <= 1'b0;
      eng_st              <= E_IDLE;
      pass                <= '0;
      idx                 <= '0;
      send_bank           <= 1'b0;
      fcnt                <= '0;
      fv                  <= 1'b0;
      fsop                <= 1'b0;
      feop                <= 1'b0;
      snk_ready_o         <= 1'b0;
      src_valid_o         <= 1'b0;
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      overflow_o          <= 1'b0;
    end else begin
      bank_st             <= bank_st_nxt;
      bank_len            <= bank_len_nxt;
      bank_desc           <= bank_desc_nxt;
      wr_bank             <= wr_bank_nxt;
      cnt                 <= cnt_nxt;
      sort_bank           <= sort_bank_nxt;
      eng_st              <= eng_st_nxt;
      pass                <= pass_nxt;
      idx                 <= idx_nxt;
      send_bank           <= send_bank_nxt;
      fcnt                <= fcnt_nxt;
      fv                  <= fv_nxt;
      fsop                <= fsop_nxt;
      feop                <= feop_nxt;
      snk_ready_o         <= snk_ready_nxt;
      src_valid_o         <= src_valid_nxt;
      src_data_o          <= src_data_nxt;
      src_startofpacket_o <= src_sop_nxt;
      src_endofpacket_o   <= src_eop_nxt;
      overflow_o          <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_sorting_pp.sv
// Scoreboard bench for sorting_pp: stimulus pushes expected beats, a monitor pops and compares.
module tb_sorting_pp;

  localparam int unsigned DW   = 8;
  localparam int unsigned MAXL = 16;

  logic          clk_i;
  logic          arst_n_i;
  logic [DW-1:0] snk_data_i;
  logic          snk_startofpacket_i;
  logic          snk_endofpacket_i;
  logic          snk_valid_i;
  logic          snk_ready_o;
  logic          sort_desc_i;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          src_valid_o;
  logic          src_ready_i;
  logic          overflow_o;

  sorting_pp #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i               (clk_i),
    .arst_n_i            (arst_n_i),
    .snk_data_i          (snk_data_i),
    .snk_startofpacket_i (snk_startofpacket_i),
    .snk_endofpacket_i   (snk_endofpacket_i),
    .snk_valid_i         (snk_valid_i),
    .snk_ready_o         (snk_ready_o),
    .sort_desc_i         (sort_desc_i),
    .src_data_o          (src_data_o),
    .src_startofpacket_o (src_startofpacket_o),
    .src_endofpacket_o   (src_endofpacket_o),
    .src_valid_o         (src_valid_o),
    .src_ready_i         (src_ready_i),
    .overflow_o          (overflow_o)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   beats     = 0;
  int   ovf_seen  = 0;
  int   stall_cnt = 0;
  bit   toggle_mode = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_snk_ready"}, int'(snk_ready_o), 0);
    chk({name, "_src_valid"}, int'(src_valid_o), 0);
    chk({name, "_src_data"},  int'(src_data_o), 0);
    chk({name, "_src_sop"},   int'(src_startofpacket_o), 0);
    chk({name, "_src_eop"},   int'(src_endofpacket_o), 0);
    chk({name, "_overflow"},  int'(overflow_o), 0);
  endtask

  task automatic align();
    @(posedge clk_i);
    #1;
  endtask

  // One sink beat; must be entered just after a rising edge
  task automatic beat(input logic [DW-1:0] d, input logic sop, input logic eop, input logic desc);
    int w;
    w = 0;
    snk_data_i          = d;
    snk_startofpacket_i = sop;
    snk_endofpacket_i   = eop;
    sort_desc_i         = desc;
    snk_valid_i         = 1'b1;
    @(negedge clk_i);
    while (!snk_ready_o && w < 2000) begin
      w++;
      @(negedge clk_i);
    end
    if (!snk_ready_o) begin
      checks++;
      failures++;
      $display("FAIL sink_timeout: snk_ready_o=0 after %0d cycles, required 1", w);
    end
    stall_cnt += w;
    @(posedge clk_i);
    #1;
    snk_valid_i         = 1'b0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i   = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] v[$], input logic desc);
    align();
    foreach (v[i]) beat(v[i], (i == 0), (i == v.size() - 1), desc);
  endtask

  task automatic push_exp(input logic [DW-1:0] v[$]);
    exp_t e;
    foreach (v[i]) begin
      e.d   = v[i];
      e.sop = (i == 0);
      e.eop = (i == v.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || src_valid_o) && w < 3000) begin
      @(negedge clk_i);
      w++;
    end
    repeat (4) @(negedge clk_i);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  // Source ready: steady 1, or alternating 1010.. when toggle_mode is set
  initial begin
    src_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (toggle_mode) src_ready_i = ~src_ready_i;
      else             src_ready_i = 1'b1;
    end
  end

  // Monitor: compare accepted beats to the scoreboard and check hold under backpressure
  initial begin : monitor
    logic          stall;
    logic [DW-1:0] pd;
    logic          ps, pe;
    exp_t          e;
    stall = 1'b0;
    pd    = '0;
    ps    = 1'b0;
    pe    = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!arst_n_i) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", int'(src_valid_o), 1);
          chk("hold_data",  int'(src_data_o), int'(pd));
          chk("hold_sop",   int'(src_startofpacket_o), int'(ps));
          chk("hold_eop",   int'(src_endofpacket_o), int'(pe));
        end
        if (src_valid_o && src_ready_i) begin
          beats++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: data=%0d with empty scoreboard", src_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", int'(src_data_o), int'(e.d));
            chk("out_sop",  int'(src_startofpacket_o), int'(e.sop));
            chk("out_eop",  int'(src_endofpacket_o), int'(e.eop));
          end
          stall = 1'b0;
        end else if (src_valid_o) begin
          stall = 1'b1;
          pd    = src_data_o;
          ps    = src_startofpacket_o;
          pe    = src_endofpacket_o;
        end else begin
          stall = 1'b0;
        end
        if (overflow_o) ovf_seen++;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    checks++;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    logic [DW-1:0] v[$];
    int n, w;
    arst_n_i            = 1'b0;
    snk_data_i          = '0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i   = 1'b0;
    snk_valid_i         = 1'b0;
    sort_desc_i         = 1'b0;
    #1;
    chk_zero("por");
    repeat (3) @(posedge clk_i);
    #2 arst_n_i = 1'b1;
    @(negedge clk_i);
    chk("ready_before_clk", int'(snk_ready_o), 0);
    @(posedge clk_i);
    #1;
    chk("ready_after_clk", int'(snk_ready_o), 1);

    // Basic ascending / descending / duplicates
    v = {8'd1, 8'd3, 8'd5, 8'd9};   push_exp(v);
    v = {8'd5, 8'd3, 8'd9, 8'd1};   send_pkt(v, 1'b0);
    drain("t1_asc");
    v = {8'd9, 8'd5, 8'd3, 8'd1};   push_exp(v);
    v = {8'd5, 8'd3, 8'd9, 8'd1};   send_pkt(v, 1'b1);
    drain("t2_desc");
    v = {8'd2, 8'd7, 8'd7, 8'd7};   push_exp(v);
    v = {8'd7, 8'd7, 8'd2, 8'd7};   send_pkt(v, 1'b0);
    drain("t2_dup");

    // Single-word packet
    v = {8'hA5};                    push_exp(v);
    send_pkt(v, 1'b0);
    drain("t3_single");

    // Stray beat while free is dropped; SOP mid-fill restarts the packet
    v = {8'd2, 8'd3};               push_exp(v);
    align();
    beat(8'h77, 1'b0, 1'b1, 1'b0);
    beat(8'd4,  1'b1, 1'b0, 1'b1);
    beat(8'd6,  1'b0, 1'b0, 1'b1);
    beat(8'd3,  1'b1, 1'b0, 1'b0);
    beat(8'd2,  1'b0, 1'b1, 1'b0);
    drain("restart");

    // Overflow: MAXL+3 descending beats, first MAXL kept and sorted ascending
    v.delete();
    for (int i = 0; i < int'(MAXL); i++) v.push_back(DW'(i + 3));
    push_exp(v);
    align();
    for (int i = 0; i < int'(MAXL) + 3; i++)
      beat(DW'(int'(MAXL) + 2 - i), (i == 0), (i == int'(MAXL) + 2), 1'b0);
    @(negedge clk_i);
    chk("ovf_pulse", int'(overflow_o), 1);
    @(negedge clk_i);
    chk("ovf_one_cycle", int'(overflow_o), 0);
    drain("t4_ovf");

    // Back-to-back packets with alternating source ready
    toggle_mode = 1'b1;
    v = {8'd1, 8'd3, 8'd5, 8'd9};   push_exp(v);
    v = {8'd8, 8'd6, 8'd4, 8'd2};   push_exp(v);
    v = {8'd5, 8'd3, 8'd9, 8'd1};   send_pkt(v, 1'b0);
    stall_cnt = 0;
    v = {8'd4, 8'd8, 8'd6, 8'd2};
    foreach (v[i]) beat(v[i], (i == 0), (i == 3), 1'b1);
    chk("t5_b_ready_stalls", stall_cnt, 0);
    drain("t5_b2b");
    toggle_mode = 1'b0;

    // Reset in the middle of a fill
    align();
    beat(8'h10, 1'b1, 1'b0, 1'b0);
    beat(8'h20, 1'b0, 1'b0, 1'b0);
    #1 arst_n_i = 1'b0;
    #1 chk_zero("rst_fill");
    @(posedge clk_i);
    #2 arst_n_i = 1'b1;
    @(posedge clk_i);
    #1 chk("rst_fill_ready", int'(snk_ready_o), 1);

    // Reset in the middle of a send
    v = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}; push_exp(v);
    v = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; send_pkt(v, 1'b0);
    n = beats;
    w = 0;
    while (beats < n + 3 && w < 1000) begin
      @(negedge clk_i);
      w++;
    end
    chk("t6_send_started", int'(beats >= n + 3), 1);
    @(posedge clk_i);
    #2 arst_n_i = 1'b0;
    #1 chk_zero("rst_send");
    exp_q.delete();
    @(posedge clk_i);
    #2 arst_n_i = 1'b1;
    @(posedge clk_i);
    #1 chk("rst_send_ready", int'(snk_ready_o), 1);
    v = {8'd1, 8'd2};               push_exp(v);
    v = {8'd2, 8'd1};               send_pkt(v, 1'b0);
    drain("t6_after_rst");

    chk("ovf_count", ovf_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
